stream_merge_multi: RTL and testbench

N-channel packet stream merger with registered output: each input channel carries SoP/EoP-framed packets under valid/ready flow control, and whole packets are granted atomically to a single output stream. It generalises the two-input merge ahead of the UART packet transmitter, so any number of sources can share the UART Tx path. Arbitration is selectable between round-robin and fixed priority. Stray mid-packet beats on ungranted channels are drained and counted.

---
 rtl/stream_merge_multi_pkg.sv | 22 ++
 rtl/stream_merge_multi_rr_select.sv | 51 +++++
 rtl/stream_merge_multi.sv | 173 +++++++++++++++++
 tb/tb_stream_merge_multi.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_merge_multi_pkg.sv
// Shared types for the N-channel packet merger: arbitration mode codes,
// merge FSM states and a small popcount helper for the drop counter.
package stream_merge_multi_pkg;

    localparam logic MERGE_RR       = 1'b0;
    localparam logic MERGE_PRIORITY = 1'b1;

    typedef enum logic {
        IDLE,
        LOCKED
    } mergeState_e;

    function automatic logic [4:0] popCount16(input logic [15:0] vec);
        logic [4:0] count;
        count = '0;
        for (int i = 0; i < 16; i++) begin
            count = count + {4'b0000, vec[i]};
        end
        return count;
    endfunction

endpackage

// File: rtl/stream_merge_multi_rr_select.sv
// Combinational N-way winner select: round-robin from ptr+1 (wrapping
// modulo N) or fixed priority (lowest index), as one-hot plus index.
module rr_select
    import stream_merge_multi_pkg::*;
#(
    parameter int N  = 4,
    parameter int CW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [CW-1:0] ptr_i,
    input  logic          mode_i,
    output logic [N-1:0]  oneHot_o,
    output logic [CW-1:0] index_o,
    output logic          found_o
);

    localparam logic [CW:0] NUM = (CW + 1)'(N);

    logic [CW:0] probe;

    // Both searches walk candidates in reverse so the preferred one is written last.
    always_comb begin
        oneHot_o = '0;
        index_o  = '0;
        found_o  = 1'b0;
        probe    = '0;
        if (mode_i == MERGE_PRIORITY) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (req_i[i]) begin
                    index_o = CW'(i);
                    found_o = 1'b1;
                end
            end
        end else begin
            for (int k = N; k >= 1; k--) begin
                probe = {1'b0, ptr_i} + (CW + 1)'(k);
                if (probe >= NUM) begin
                    probe = probe - NUM;
                end
                if (req_i[probe[CW-1:0]]) begin
                    index_o = probe[CW-1:0];
                    found_o = 1'b1;
                end
            end
        end
        if (found_o) begin
            oneHot_o[index_o] = 1'b1;
        end
    end

endmodule

// File: rtl/stream_merge_multi.sv
// N-channel SoP/EoP packet merger: whole packets granted atomically to one
// registered output stream; stray mid-packet beats are drained and counted.
module stream_merge_multi
    import stream_merge_multi_pkg::*;
#(
    parameter  int N     = 4,
    parameter  int WIDTH = 32,
    localparam int CW    = $clog2(N)
) (
    input  logic               ipClk,
    input  logic               Reset,
    input  logic               ipMode,
    input  logic [N-1:0]       ipSoP,
    input  logic [N-1:0]       ipEoP,
    input  logic [N*WIDTH-1:0] ipData,
    input  logic [N-1:0]       ipValid,
    output logic [N-1:0]       opReady,
    output logic               opSoP,
    output logic               opEoP,
    output logic [WIDTH-1:0]   opData,
    output logic               opValid,
    input  logic               ipReady,
    output logic [CW-1:0]      opChannel,
    output logic [15:0]        opDropCount
);

    mergeState_e      state_q, state_d;
    logic [CW-1:0]    grant_q, grant_d;
    logic [N-1:0]     grantOH_q, grantOH_d;
    logic [CW-1:0]    lastGrant_q, lastGrant_d;
    logic             opValid_q, opValid_d;
    logic             opSoP_q, opSoP_d;
    logic             opEoP_q, opEoP_d;
    logic [WIDTH-1:0] opData_q, opData_d;
    logic [CW-1:0]    opChannel_q, opChannel_d;
    logic [15:0]      dropCount_q, dropCount_d;

    logic             outAdvance, accept, grantValid, grantSoP, grantEoP;
    logic [N-1:0]     drainMask, idleReq, handReq;
    logic [WIDTH-1:0] selData;
    logic [16:0]      dropSum;
    logic [N-1:0]     idleOH, handOH;
    logic [CW-1:0]    idleIdx, handIdx;
    logic             idleFound, handFound;

    // grantOH_q is all-zero in IDLE, so it doubles as the "locked channel" mask.
    assign outAdvance = !opValid_q || ipReady;
    assign grantValid = |(ipValid & grantOH_q);
    assign grantSoP   = |(ipSoP & grantOH_q);
    assign grantEoP   = |(ipEoP & grantOH_q);
    assign accept     = (state_q == LOCKED) && grantValid && outAdvance;
    assign drainMask  = ipValid & ~ipSoP & ~grantOH_q;
    assign opReady    = drainMask | (grantOH_q & {N{outAdvance}});
    assign idleReq    = ipValid & ipSoP;
    assign handReq    = ipValid & ipSoP & ~grantOH_q;

    rr_select #(.N(N), .CW(CW)) idleArb (
        .req_i    (idleReq),
        .ptr_i    (lastGrant_q),
        .mode_i   (ipMode),
        .oneHot_o (idleOH),
        .index_o  (idleIdx),
        .found_o  (idleFound)
    );

    rr_select #(.N(N), .CW(CW)) handArb (
        .req_i    (handReq),
        .ptr_i    (lastGrant_q),
        .mode_i   (ipMode),
        .oneHot_o (handOH),
        .index_o  (handIdx),
        .found_o  (handFound)
    );

    always_comb begin
        selData = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_q == CW'(i)) begin
                selData = ipData[i*WIDTH +: WIDTH];
            end
        end
    end

    // An accepted EoP re-arbitrates in the same cycle so packets run back to back.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        grantOH_d   = grantOH_q;
        lastGrant_d = lastGrant_q;
        case (state_q)
            IDLE: begin
                if (idleFound) begin
                    grant_d     = idleIdx;
                    grantOH_d   = idleOH;
                    lastGrant_d = idleIdx;
                    state_d     = LOCKED;
                end
            end
            LOCKED: begin
                if (accept && grantEoP) begin
                    if (handFound) begin
                        grant_d     = handIdx;
                        grantOH_d   = handOH;
                        lastGrant_d = handIdx;
                    end else begin
                        grantOH_d = '0;
                        state_d   = IDLE;
                    end
                end
            end
            default: begin
                grantOH_d = '0;
                state_d   = IDLE;
            end
        endcase
    end

    always_comb begin
        opValid_d   = opValid_q;
        opSoP_d     = opSoP_q;
        opEoP_d     = opEoP_q;
        opData_d    = opData_q;
        opChannel_d = opChannel_q;
        if (accept) begin
            opValid_d   = 1'b1;
            opSoP_d     = grantSoP;
            opEoP_d     = grantEoP;
            opData_d    = selData;
            opChannel_d = grant_q;
        end else if (ipReady) begin
            opValid_d = 1'b0;
        end
    end

    always_comb begin
        dropSum     = {1'b0, dropCount_q} + {12'b0, popCount16(16'(drainMask))};
        dropCount_d = dropSum[16] ? 16'hFFFF : dropSum[15:0];
    end

    always_ff @(posedge ipClk) begin
        if (Reset) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            grantOH_q   <= '0;
            lastGrant_q <= CW'(N - 1);
            opValid_q   <= 1'b0;
            opSoP_q     <= 1'b0;
            opEoP_q     <= 1'b0;
            opData_q    <= '0;
            opChannel_q <= '0;
            dropCount_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            grantOH_q   <= grantOH_d;
            lastGrant_q <= lastGrant_d;
            opValid_q   <= opValid_d;
            opSoP_q     <= opSoP_d;
            opEoP_q     <= opEoP_d;
            opData_q    <= opData_d;
            opChannel_q <= opChannel_d;
            dropCount_q <= dropCount_d;
        end
    end

    assign opValid     = opValid_q;
    assign opSoP       = opSoP_q;
    assign opEoP       = opEoP_q;
    assign opData      = opData_q;
    assign opChannel   = opChannel_q;
    assign opDropCount = dropCount_q;

endmodule

// File: tb/tb_stream_merge_multi.sv
// Directed bench for stream_merge_multi (N=4, WIDTH=32): per-channel beat
// sources follow the opReady handshake, output beats are logged and checked.
module tb_stream_merge_multi;

    logic         ipClk = 1'b0;
    logic         Reset;
    logic         ipMode;
    logic [3:0]   ipSoP, ipEoP, ipValid, opReady;
    logic [127:0] ipData;
    logic         opSoP, opEoP, opValid, ipReady;
    logic [31:0]  opData;
    logic [1:0]   opChannel;
    logic [15:0]  opDropCount;

    typedef struct {
        int         step;
        logic [1:0] ch;
        logic       sop;
        logic       eop;
        logic [31:0] data;
    } beat_t;

    beat_t       outLog[$];
    bit          readyQ[$];
    logic [31:0] srcData [4][16];
    logic        srcSoP  [4][16];
    logic        srcEoP  [4][16];
    int          srcLen[4];
    int          srcIdx[4];

    int          compared = 0;
    int          mismatched = 0;
    int          stepNo = 0;
    int          startStep;
    bit          checkReadyLow = 0;
    logic        prevValid = 0, prevReady = 1, prevSoP = 0, prevEoP = 0;
    logic [1:0]  prevCh = '0;
    logic [31:0] prevData = '0;

    stream_merge_multi #(.N(4), .WIDTH(32)) dut (
        .ipClk       (ipClk),
        .Reset       (Reset),
        .ipMode      (ipMode),
        .ipSoP       (ipSoP),
        .ipEoP       (ipEoP),
        .ipData      (ipData),
        .ipValid     (ipValid),
        .opReady     (opReady),
        .opSoP       (opSoP),
        .opEoP       (opEoP),
        .opData      (opData),
        .opValid     (opValid),
        .ipReady     (ipReady),
        .opChannel   (opChannel),
        .opDropCount (opDropCount)
    );

    always #5 ipClk = ~ipClk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic clearInputs();
        ipValid = '0;
        ipSoP   = '0;
        ipEoP   = '0;
        ipData  = '0;
    endtask

    task automatic clearSources();
        for (int c = 0; c < 4; c++) begin
            srcLen[c] = 0;
            srcIdx[c] = 0;
        end
        outLog.delete();
        readyQ.delete();
    endtask

    task automatic addBeat(input int ch, input logic sop, input logic eop, input logic [31:0] data);
        if (srcLen[ch] < 16) begin
            srcSoP[ch][srcLen[ch]]  = sop;
            srcEoP[ch][srcLen[ch]]  = eop;
            srcData[ch][srcLen[ch]] = data;
            srcLen[ch]++;
        end
    endtask

    task automatic addPacket(input int ch, input int nBeats, input logic [31:0] base);
        for (int k = 0; k < nBeats; k++) begin
            addBeat(ch, k == 0, k == nBeats - 1, base + 32'(k));
        end
    endtask

    task automatic doReset();
        @(negedge ipClk);
        Reset   = 1'b1;
        ipReady = 1'b1;
        clearInputs();
        clearSources();
        repeat (2) @(negedge ipClk);
        Reset     = 1'b0;
        prevValid = 1'b0;
        prevReady = 1'b1;
    endtask

    // Inputs change just after the falling edge; handshakes are decided before the next rising edge.
    task automatic applyStimulus();
        @(negedge ipClk);
        stepNo++;
        if (prevValid && !prevReady) begin
            checkOutput("hold", {opValid, opSoP, opEoP, opChannel, opData},
                        {1'b1, prevSoP, prevEoP, prevCh, prevData});
        end
        for (int c = 0; c < 4; c++) begin
            if (srcIdx[c] < srcLen[c]) begin
                ipValid[c]           = 1'b1;
                ipSoP[c]             = srcSoP[c][srcIdx[c]];
                ipEoP[c]             = srcEoP[c][srcIdx[c]];
                ipData[c*32 +: 32]   = srcData[c][srcIdx[c]];
            end else begin
                ipValid[c]           = 1'b0;
                ipSoP[c]             = 1'b0;
                ipEoP[c]             = 1'b0;
                ipData[c*32 +: 32]   = '0;
            end
        end
        ipReady = (readyQ.size() > 0) ? readyQ.pop_front() : 1'b1;
        #1;
        if (checkReadyLow && opValid && !ipReady) begin
            checkOutput("readyLow", {60'd0, opReady}, 64'd0);
        end
        for (int c = 0; c < 4; c++) begin
            if (ipValid[c] && opReady[c]) srcIdx[c]++;
        end
        if (opValid && ipReady) begin
            outLog.push_back('{step: stepNo, ch: opChannel, sop: opSoP, eop: opEoP, data: opData});
        end
        prevValid = opValid;
        prevReady = ipReady;
        prevSoP   = opSoP;
        prevEoP   = opEoP;
        prevCh    = opChannel;
        prevData  = opData;
    endtask

    task automatic runUntil(input int nBeats, input int budget, input string tag);
        for (int i = 0; i < budget && outLog.size() < nBeats; i++) begin
            applyStimulus();
        end
        repeat (4) applyStimulus();
        checkOutput({tag, "_beats"}, 64'(outLog.size()), 64'(nBeats));
    endtask

    task automatic checkBeat(input string tag, input int idx, input logic [1:0] ch,
                             input logic sop, input logic eop, input logic [31:0] data);
        if (idx < outLog.size()) begin
            checkOutput(tag, {outLog[idx].sop, outLog[idx].eop, outLog[idx].ch, outLog[idx].data},
                        {sop, eop, ch, data});
        end else begin
            compared++;
            mismatched++;
            $error("[TB] FAIL %s: observed no beat expected ch%0d data %h", tag, ch, data);
        end
    endtask

    initial begin
        Reset   = 1'b1;
        ipMode  = 1'b0;
        ipReady = 1'b1;
        clearInputs();
        clearSources();
        doReset();

        checkOutput("rst_opValid",     opValid,     0);
        checkOutput("rst_opSoP",       opSoP,       0);
        checkOutput("rst_opEoP",       opEoP,       0);
        checkOutput("rst_opData",      opData,      0);
        checkOutput("rst_opChannel",   opChannel,   0);
        checkOutput("rst_opDropCount", opDropCount, 0);
        checkOutput("rst_opReady",     opReady,     0);

        // Channels 0 and 2 request together: channel 0 first, channel 2 with no gap.
        clearSources();
        addPacket(0, 3, 32'h1111_0000);
        addPacket(2, 3, 32'h3333_0000);
        startStep = stepNo + 1;
        runUntil(6, 30, "t1");
        checkBeat("t1_b0", 0, 2'd0, 1'b1, 1'b0, 32'h1111_0000);
        checkBeat("t1_b1", 1, 2'd0, 1'b0, 1'b0, 32'h1111_0001);
        checkBeat("t1_b2", 2, 2'd0, 1'b0, 1'b1, 32'h1111_0002);
        checkBeat("t1_b3", 3, 2'd2, 1'b1, 1'b0, 32'h3333_0000);
        checkBeat("t1_b4", 4, 2'd2, 1'b0, 1'b0, 32'h3333_0001);
        checkBeat("t1_b5", 5, 2'd2, 1'b0, 1'b1, 32'h3333_0002);
        if (outLog.size() >= 6) begin
            checkOutput("t1_latency", 64'(outLog[0].step - startStep), 64'd2);
            checkOutput("t1_noGap",   64'(outLog[5].step - outLog[0].step), 64'd5);
        end

        // Round-robin fairness with every channel offering single-beat packets.
        doReset();
        for (int p = 0; p < 2; p++) begin
            for (int c = 0; c < 4; c++) begin
                addPacket(c, 1, 32'h5000_0000 + 32'(c * 16 + p));
            end
        end
        runUntil(8, 40, "rr");
        checkBeat("rr_0", 0, 2'd0, 1'b1, 1'b1, 32'h5000_0000);
        checkBeat("rr_1", 1, 2'd1, 1'b1, 1'b1, 32'h5000_0010);
        checkBeat("rr_2", 2, 2'd2, 1'b1, 1'b1, 32'h5000_0020);
        checkBeat("rr_3", 3, 2'd3, 1'b1, 1'b1, 32'h5000_0030);
        checkBeat("rr_4", 4, 2'd0, 1'b1, 1'b1, 32'h5000_0001);
        checkBeat("rr_5", 5, 2'd1, 1'b1, 1'b1, 32'h5000_0011);
        checkBeat("rr_6", 6, 2'd2, 1'b1, 1'b1, 32'h5000_0021);
        checkBeat("rr_7", 7, 2'd3, 1'b1, 1'b1, 32'h5000_0031);

        // Fixed priority: after a channel-2 grant, round-robin would pick 3; priority picks 1.
        ipMode = 1'b1;
        clearSources();
        addPacket(2, 1, 32'h6200_0000);
        runUntil(1, 20, "pri_a");
        checkBeat("pri_a0", 0, 2'd2, 1'b1, 1'b1, 32'h6200_0000);
        clearSources();
        addPacket(1, 2, 32'h6100_0000);
        addPacket(3, 2, 32'h6300_0000);
        runUntil(4, 30, "pri_b");
        checkBeat("pri_b0", 0, 2'd1, 1'b1, 1'b0, 32'h6100_0000);
        checkBeat("pri_b1", 1, 2'd1, 1'b0, 1'b1, 32'h6100_0001);
        checkBeat("pri_b2", 2, 2'd3, 1'b1, 1'b0, 32'h6300_0000);
        checkBeat("pri_b3", 3, 2'd3, 1'b0, 1'b1, 32'h6300_0001);
        ipMode = 1'b0;

        // Backpressure mid-packet: ipReady 1,0,0,1 while beat 1 sits in the output register.
        clearSources();
        addPacket(0, 4, 32'h7777_0000);
        readyQ = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        checkReadyLow = 1'b1;
        runUntil(4, 30, "bp");
        checkReadyLow = 1'b0;
        checkBeat("bp_b0", 0, 2'd0, 1'b1, 1'b0, 32'h7777_0000);
        checkBeat("bp_b1", 1, 2'd0, 1'b0, 1'b0, 32'h7777_0001);
        checkBeat("bp_b2", 2, 2'd0, 1'b0, 1'b0, 32'h7777_0002);
        checkBeat("bp_b3", 3, 2'd0, 1'b0, 1'b1, 32'h7777_0003);

        // Stray beats on channel 2 while channel 0 carries a packet.
        doReset();
        addPacket(0, 4, 32'h9999_0000);
        for (int k = 0; k < 5; k++) begin
            addBeat(2, 1'b0, 1'b0, 32'hDEAD_0000 + 32'(k));
        end
        runUntil(4, 30, "drain");
        checkBeat("drain_b0", 0, 2'd0, 1'b1, 1'b0, 32'h9999_0000);
        checkBeat("drain_b1", 1, 2'd0, 1'b0, 1'b0, 32'h9999_0001);
        checkBeat("drain_b2", 2, 2'd0, 1'b0, 1'b0, 32'h9999_0002);
        checkBeat("drain_b3", 3, 2'd0, 1'b0, 1'b1, 32'h9999_0003);
        checkOutput("drain_srcDone", 64'(srcIdx[2]), 64'd5);
        checkOutput("drain_count",   opDropCount, 16'd5);

        // Reset while beat 1 of a 4-beat packet is in the output register.
        clearSources();
        addPacket(0, 4, 32'hBBBB_0000);
        for (int i = 0; i < 20 && srcIdx[0] < 2; i++) begin
            applyStimulus();
        end
        checkOutput("rstmid_reached", 64'(srcIdx[0]), 64'd2);
        @(negedge ipClk);
        checkOutput("rstmid_pre", {opValid, opData}, {1'b1, 32'hBBBB_0001});
        Reset = 1'b1;
        clearInputs();
        clearSources();
        @(negedge ipClk);
        checkOutput("rstmid_valid", opValid,     0);
        checkOutput("rstmid_flags", {opSoP, opEoP}, 0);
        checkOutput("rstmid_data",  opData,      0);
        checkOutput("rstmid_chan",  opChannel,   0);
        checkOutput("rstmid_drop",  opDropCount, 0);
        checkOutput("rstmid_ready", opReady,     0);
        Reset     = 1'b0;
        prevValid = 1'b0;
        prevReady = 1'b1;
        addPacket(0, 2, 32'hCCCC_0000);
        runUntil(2, 20, "post");
        checkBeat("post_b0", 0, 2'd0, 1'b1, 1'b0, 32'hCCCC_0000);
        checkBeat("post_b1", 1, 2'd0, 1'b0, 1'b1, 32'hCCCC_0001);

        // Drop counter saturation: 4 strays/cycle up to 0xFFFC, +3 lands on 0xFFFF, +4 must not wrap.
        doReset();
        for (int i = 0; i < 16383; i++) begin
            @(negedge ipClk);
            ipValid = 4'hF;
            ipSoP   = 4'h0;
            ipEoP   = 4'h0;
            if (i == 0) begin
                #1;
                checkOutput("sat_drainReady", opReady, 4'hF);
            end
        end
        @(negedge ipClk);
        checkOutput("sat_fffc", opDropCount, 16'hFFFC);
        ipValid = 4'h7;
        @(negedge ipClk);
        checkOutput("sat_ffff", opDropCount, 16'hFFFF);
        ipValid = 4'hF;
        @(negedge ipClk);
        checkOutput("sat_hold", opDropCount, 16'hFFFF);
        clearInputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
